timestamp_capture: RTL and testbench

//  SpartanMC peripheral downstream of the timestamp counter peripheral.
//  - Captures the 72-bit {lpt_counter, hpt_counter} value on edges of an external event input.
//  - Stores captures in a small FIFO; the CPU reads them through the peripheral bus.
//  - Used for time-tagging external pulses (PPS, sensor triggers) against the system timebase.

---
 rtl/timestamp_capture.sv | 204 ++++++++++++++++++++
 tb/tb_timestamp_capture.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/timestamp_capture.sv
// -----------------------------------------------------------------------------
// timestamp_capture
//   Peripheral that sits downstream of the timestamp counter. It captures the
//   72-bit {lpt_counter, hpt_counter} timebase on selected edges of an
//   asynchronous event input. Captures go into a small FIFO that the CPU reads
//   over the peripheral bus.
//
//   Optional feature macro: TS_CAPTURE_IRQ_EN
//     defined   : adds output 'irq' and makes CONTROL[3] (irq enable) writable
//     undefined : no irq port, CONTROL[3] reads 0
//
// Ports
//   clk_peri     in   1   peripheral clock, shared with the timestamp counter
//   reset        in   1   synchronous, active-high reset
//   addr_peri    in  10   peripheral address ([9:3] select, [2:0] register)
//   access_peri  in   1   peripheral access strobe
//   wr_peri      in   1   write strobe
//   rd_peri      in   1   read strobe
//   do_peri      in  18   CPU write data
//   di_peri      out 18   CPU read data, 0 when not selected for a read
//   lpt_counter  in  36   seconds count
//   hpt_counter  in  36   tick count
//   event_in     in   1   asynchronous external event
//   irq          out  1   (TS_CAPTURE_IRQ_EN only) FIFO non-empty / overflow
//
// Register map (addr_peri[2:0])
//   0 CAP_LPT_LOW  1 CAP_LPT_HIGH  2 CAP_HPT_LOW  3 CAP_HPT_HIGH (read pops)
//   4 STATUS  [0] empty [1] full [2] overflow [6:3] count
//   5 CONTROL [0] enable [1] rising [2] falling [3] irq enable; [17]=1 flush
//   6,7 read 0
// -----------------------------------------------------------------------------
module timestamp_capture #(
  parameter logic [9:0] BASE_ADR        = 10'h000,
  parameter int         FIFO_DEPTH_LOG2 = 2,
  parameter int         SYNC_STAGES     = 2
) (
  input  logic        clk_peri,
  input  logic        reset,
  input  logic [9:0]  addr_peri,
  input  logic        access_peri,
  input  logic        wr_peri,
  input  logic        rd_peri,
  input  logic [17:0] do_peri,
  output logic [17:0] di_peri,
  input  logic [35:0] lpt_counter,
  input  logic [35:0] hpt_counter,
  input  logic        event_in
`ifdef TS_CAPTURE_IRQ_EN
  ,
  output logic        irq
`endif
);

  localparam int         DEPTH     = 1 << FIFO_DEPTH_LOG2;
  localparam int         PW        = FIFO_DEPTH_LOG2;
  localparam logic [6:0] BASE_ADDR = BASE_ADR[9:3];

  localparam logic [2:0] REG_LPT_LOW  = 3'd0;
  localparam logic [2:0] REG_LPT_HIGH = 3'd1;
  localparam logic [2:0] REG_HPT_LOW  = 3'd2;
  localparam logic [2:0] REG_HPT_HIGH = 3'd3;
  localparam logic [2:0] REG_STATUS   = 3'd4;
  localparam logic [2:0] REG_CONTROL  = 3'd5;

  localparam logic [PW:0] PTR_ONE = {{PW{1'b0}}, 1'b1};

  // Assemble the STATUS word from the FIFO flags.
  function automatic logic [17:0] status_word(input logic empty_f, input logic full_f,
                                              input logic ovf_f, input logic [3:0] cnt_f);
    status_word = {11'd0, cnt_f, ovf_f, full_f, empty_f};
  endfunction

  logic [SYNC_STAGES-1:0] sync;
  logic                   ev_prev;
  logic                   ev_sync;
  logic                   rise;
  logic                   fall;
  logic                   capture;

  logic [71:0] mem [DEPTH];
  logic [PW:0] wr_ptr;
  logic [PW:0] rd_ptr;
  logic [PW:0] count;
  logic        overflow;
  logic        empty;
  logic        full;
  logic [71:0] head;
  logic [3:0]  ctrl;

  logic        sel;
  logic        rd_sel;
  logic        wr_sel;
  logic [2:0]  reg_idx;
  logic        ctrl_wr;
  logic        flush;
  logic        pop;
  logic        push;
  logic        ovf_set;
  logic        unused_bits;

  assign ev_sync = sync[SYNC_STAGES-1];
  assign rise    = ev_sync & ~ev_prev;
  assign fall    = ~ev_sync & ev_prev;
  assign capture = ctrl[0] & ((ctrl[1] & rise) | (ctrl[2] & fall));

  assign count = wr_ptr - rd_ptr;
  assign empty = (wr_ptr == rd_ptr);
  // Same slot index but different wrap bit means the writer is a full lap ahead.
  assign full  = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
  assign head  = mem[rd_ptr[PW-1:0]];

  assign sel     = access_peri & (addr_peri[9:3] == BASE_ADDR);
  assign rd_sel  = sel & rd_peri;
  assign wr_sel  = sel & wr_peri;
  assign reg_idx = addr_peri[2:0];
  assign ctrl_wr = wr_sel & (reg_idx == REG_CONTROL);
  assign flush   = ctrl_wr & do_peri[17];
  assign pop     = rd_sel & (reg_idx == REG_HPT_HIGH) & ~empty;
  // A pop in the same cycle frees the slot, so a full FIFO can still accept.
  assign push    = capture & ~flush & (~full | pop);
  assign ovf_set = capture & ~flush & full & ~pop;

  assign unused_bits = ^do_peri[16:3];

  // Event synchronizer and edge-detect flop; they run regardless of enable.
  always_ff @(posedge clk_peri) begin
    if (reset) begin
      sync    <= '0;
      ev_prev <= 1'b0;
    end else begin
      sync    <= {sync[SYNC_STAGES-2:0], event_in};
      ev_prev <= ev_sync;
    end
  end

  // FIFO pointers and sticky overflow; flush takes priority over capture.
  always_ff @(posedge clk_peri) begin
    if (reset || flush) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      if (ovf_set) begin
        overflow <= 1'b1;
      end
    end
  end

  // FIFO storage; entries need no reset because the pointers define validity.
  always_ff @(posedge clk_peri) begin
    if (push && !reset) begin
      mem[wr_ptr[PW-1:0]] <= {lpt_counter, hpt_counter};
    end
  end

  // CONTROL register.
  always_ff @(posedge clk_peri) begin
    if (reset) begin
      ctrl <= 4'h0;
    end else if (ctrl_wr) begin
`ifdef TS_CAPTURE_IRQ_EN
      ctrl <= do_peri[3:0];
`else
      ctrl <= {1'b0, do_peri[2:0]};
`endif
    end
  end

`ifdef TS_CAPTURE_IRQ_EN
  // Registered interrupt request.
  always_ff @(posedge clk_peri) begin
    if (reset) begin
      irq <= 1'b0;
    end else begin
      irq <= (~empty | overflow) & ctrl[3];
    end
  end
`endif

  // Combinational read mux; capture words read 0 while the FIFO is empty.
  always_comb begin
    di_peri = 18'h0;
    if (rd_sel) begin
      case (reg_idx)
        REG_LPT_LOW:  di_peri = empty ? 18'h0 : head[53:36];
        REG_LPT_HIGH: di_peri = empty ? 18'h0 : head[71:54];
        REG_HPT_LOW:  di_peri = empty ? 18'h0 : head[17:0];
        REG_HPT_HIGH: di_peri = empty ? 18'h0 : head[35:18];
        REG_STATUS:   di_peri = status_word(empty, full, overflow, 4'(count));
        REG_CONTROL:  di_peri = {14'd0, ctrl};
        default:      di_peri = 18'h0;
      endcase
    end else begin
      di_peri = 18'h0;
    end
  end

endmodule

// File: tb/tb_timestamp_capture.sv
// -----------------------------------------------------------------------------
// tb_timestamp_capture
//   Directed bench for timestamp_capture. Expected captures are pushed into a
//   queue when an event edge is driven and popped when the entry is read back.
//   hpt_counter advances by one every clock, so a capture triggered by an edge
//   driven while hpt = v carries hpt = v + SYNC_STAGES.
// -----------------------------------------------------------------------------
module tb_timestamp_capture;

  localparam int SYNC  = 2;
  localparam int DEPTH = 4;

  logic        clk_peri = 1'b0;
  logic        reset;
  logic [9:0]  addr_peri;
  logic        access_peri;
  logic        wr_peri;
  logic        rd_peri;
  logic [17:0] do_peri;
  logic [17:0] di_peri;
  logic [35:0] lpt_counter;
  logic [35:0] hpt_counter;
  logic        event_in;
`ifdef TS_CAPTURE_IRQ_EN
  logic        irq;
`endif

  int errors = 0;
  int checks = 0;
  logic [71:0] exp_q[$];
  logic [3:0]  m_ctrl;
  logic        m_ovf;

  timestamp_capture #(
    .BASE_ADR(10'h000),
    .FIFO_DEPTH_LOG2(2),
    .SYNC_STAGES(SYNC)
  ) dut (
    .clk_peri(clk_peri),
    .reset(reset),
    .addr_peri(addr_peri),
    .access_peri(access_peri),
    .wr_peri(wr_peri),
    .rd_peri(rd_peri),
    .do_peri(do_peri),
    .di_peri(di_peri),
    .lpt_counter(lpt_counter),
    .hpt_counter(hpt_counter),
    .event_in(event_in)
`ifdef TS_CAPTURE_IRQ_EN
    ,
    .irq(irq)
`endif
  );

  always #5 clk_peri = ~clk_peri;

  task automatic check(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_peri);
    #1;
    hpt_counter = hpt_counter + 36'd1;
  endtask

  task automatic settle();
    repeat (SYNC + 1) tick();
  endtask

  task automatic rd(input logic [9:0] a, output logic [17:0] d);
    addr_peri   = a;
    access_peri = 1'b1;
    rd_peri     = 1'b1;
    #2;
    d = di_peri;
    tick();
    access_peri = 1'b0;
    rd_peri     = 1'b0;
  endtask

  task automatic wr(input logic [9:0] a, input logic [17:0] v);
    addr_peri   = a;
    do_peri     = v;
    access_peri = 1'b1;
    wr_peri     = 1'b1;
    tick();
    access_peri = 1'b0;
    wr_peri     = 1'b0;
    if (a == 10'd5) begin
`ifdef TS_CAPTURE_IRQ_EN
      m_ctrl = v[3:0];
`else
      m_ctrl = {1'b0, v[2:0]};
`endif
      if (v[17]) begin
        exp_q.delete();
        m_ovf = 1'b0;
      end
    end
  endtask

  task automatic drive_event(input logic lvl);
    logic cap;
    cap = m_ctrl[0] && ((lvl && m_ctrl[1]) || (!lvl && m_ctrl[2]));
    event_in = lvl;
    if (cap) begin
      if (exp_q.size() < DEPTH) exp_q.push_back({lpt_counter, hpt_counter + 36'(SYNC)});
      else m_ovf = 1'b1;
    end
  endtask

  task automatic pulse();
    drive_event(1'b1);
    settle();
    drive_event(1'b0);
    settle();
  endtask

  task automatic check_status(input string tag);
    logic [17:0] d;
    logic [17:0] e;
    e = {11'd0, 4'(exp_q.size()), m_ovf, exp_q.size() == DEPTH, exp_q.size() == 0};
    rd(10'd4, d);
    check(tag, {54'd0, d}, {54'd0, e});
  endtask

  task automatic check_entry(input string tag);
    logic [17:0] d0, d1, d2, d3;
    logic [71:0] e;
    rd(10'd0, d0);
    rd(10'd1, d1);
    rd(10'd2, d2);
    rd(10'd3, d3);
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 72'd0;
    check({tag, "_lpt_lo"}, {54'd0, d0}, {54'd0, e[53:36]});
    check({tag, "_lpt_hi"}, {54'd0, d1}, {54'd0, e[71:54]});
    check({tag, "_hpt_lo"}, {54'd0, d2}, {54'd0, e[17:0]});
    check({tag, "_hpt_hi"}, {54'd0, d3}, {54'd0, e[35:18]});
  endtask

  initial begin
    logic [17:0] d, d0, d1, d3;
    logic [71:0] e;

    reset = 1'b1; addr_peri = 10'd0; access_peri = 1'b0; wr_peri = 1'b0;
    rd_peri = 1'b0; do_peri = 18'd0; lpt_counter = 36'd0; hpt_counter = 36'd0;
    event_in = 1'b0; m_ctrl = 4'h0; m_ovf = 1'b0;
    repeat (3) tick();
    reset = 1'b0;

    // Reset state
    check("rst_di_idle", {54'd0, di_peri}, 72'd0);
    check_status("rst_status");
    rd(10'd5, d);
    check("rst_control", {54'd0, d}, 72'd0);

    // Test 1: single rising capture, latency, word layout
    wr(10'd5, 18'h00003);
    lpt_counter = 36'd5;
    hpt_counter = 36'd998;
    drive_event(1'b1);
    repeat (SYNC) tick();
    rd(10'd4, d);
    check("t1_not_yet", {54'd0, d}, 72'h01);
    check_status("t1_status_cnt1");
    rd(10'h00C, d);
    check("t1_unselected", {54'd0, d}, 72'd0);
    check("t1_model_hpt", exp_q[0][35:0], 72'd1000);
    check_entry("t1");
    check_status("t1_empty_after");
    drive_event(1'b0);
    settle();

    // Test 2: both edges, pulse 10 clocks wide
    wr(10'd5, 18'h00007);
    lpt_counter = 36'h9_8765_4321;
    hpt_counter = 36'h3_FFFF_FFF0;
    drive_event(1'b1);
    repeat (10) tick();
    drive_event(1'b0);
    settle();
    check_status("t2_status");
    check_entry("t2_rise");
    check_entry("t2_fall");

    // Test 3: overflow on the fifth rising edge
    wr(10'd5, 18'h00003);
    for (int i = 0; i < 5; i++) begin
      lpt_counter = 36'(i + 100);
      pulse();
    end
    check_status("t3_full_ovf");
    for (int i = 0; i < DEPTH; i++) check_entry($sformatf("t3_e%0d", i));
    check_status("t3_drained");

    // Test 5: flush clears entries and overflow
    pulse();
    pulse();
    check_status("t5_before_flush");
    wr(10'd5, 18'h20003);
    check_status("t5_after_flush");
    rd(10'd0, d);
    check("t5_empty_read", {54'd0, d}, 72'd0);

    // Test 4: full FIFO, capture and pop in the same cycle
    for (int i = 0; i < DEPTH; i++) begin
      lpt_counter = 36'h8_0000_0000 | 36'(i);
      pulse();
    end
    check_status("t4_full");
    e = exp_q.pop_front();
    drive_event(1'b1);
    rd(10'd0, d0);
    rd(10'd1, d1);
    rd(10'd3, d3);
    check("t4_lpt_lo", {54'd0, d0}, {54'd0, e[53:36]});
    check("t4_lpt_hi", {54'd0, d1}, {54'd0, e[71:54]});
    check("t4_hpt_hi", {54'd0, d3}, {54'd0, e[35:18]});
    check_status("t4_no_ovf");
    drive_event(1'b0);
    settle();
    for (int i = 0; i < DEPTH; i++) check_entry($sformatf("t4_e%0d", i));
    check_status("t4_drained");

    // Empty FIFO: capture and pop read in the same cycle
    drive_event(1'b1);
    tick();
    tick();
    rd(10'd3, d);
    check("ecp_read_zero", {54'd0, d}, 72'd0);
    check_status("ecp_status");
    drive_event(1'b0);
    settle();
    check_entry("ecp");

    // Flush together with a capture
    drive_event(1'b1);
    tick();
    tick();
    wr(10'd5, 18'h20003);
    settle();
    check_status("flush_cap");
    drive_event(1'b0);
    settle();

    // Test 6: disabled, and enabling while the input is high
    wr(10'd5, 18'h00000);
    pulse();
    check_status("t6_disabled");
    drive_event(1'b1);
    settle();
    wr(10'd5, 18'h00003);
    settle();
    check_status("t6_no_false_edge");
    drive_event(1'b0);
    settle();
    wr(10'd5, 18'h0000F);
    rd(10'd5, d);
    check("t6_ctrl_readback", {54'd0, d}, {68'd0, m_ctrl});
`ifdef TS_CAPTURE_IRQ_EN
    wr(10'd5, 18'h0000B);
    check("irq_idle", {71'd0, irq}, 72'd0);
    drive_event(1'b1);
    settle();
    tick();
    check("irq_on", {71'd0, irq}, 72'd1);
    check_entry("irq_entry");
    tick();
    check("irq_off", {71'd0, irq}, 72'd0);
    drive_event(1'b0);
    settle();
`endif

    // Reset mid-operation
    wr(10'd5, 18'h00003);
    pulse();
    pulse();
    check_status("mid_two");
    reset = 1'b1;
    tick();
    reset = 1'b0;
    exp_q.delete();
    m_ctrl = 4'h0;
    m_ovf  = 1'b0;
    check_status("mid_reset_status");
    rd(10'd5, d);
    check("mid_reset_ctrl", {54'd0, d}, 72'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
